debounce_sync: RTL and testbench

Input-conditioning stage that sits directly upstream of the library's D flip-flop and register blocks. It takes a raw asynchronous 1-bit signal such as a push-button or external strobe, synchronises it into the `clk` domain, and filters out bounce. It then presents a clean registered level with its complement, matching the `q`/`q_b` pair downstream flops expect, plus single-cycle rise/fall pulses.

---
 rtl/debounce_sync_pkg.sv | 16 +
 rtl/debounce_sync_sync_chain.sv | 26 ++
 rtl/debounce_sync.sv | 96 +++++++++
 tb/tb_debounce_sync.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_sync_pkg.sv
// Shared types and defaults for the debounce/synchroniser input-conditioning blocks.
package debounce_sync_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  localparam int unsigned DEF_SYNC_STAGES = 2;

  // Counter width for a stability window: ceil(log2(n)), never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// Multi-flop synchroniser for an asynchronous 1-bit input; reusable by any block.
module sync_chain
  import debounce_sync_pkg::*;
#(
  parameter int unsigned STAGES    = DEF_SYNC_STAGES,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {STAGES{RESET_VAL}};
    end else begin
      sync <= {sync[STAGES-2:0], d};
    end
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronise and debounce a raw input; registered level, complement and edge pulses.
module debounce_sync
  import debounce_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic        RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic q_b,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             q_n, rise_n, fall_n;

  sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_VAL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (s)
  );

  // State, counter and all outputs are flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      q     <= RESET_VAL;
      q_b   <= ~RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      q     <= q_n;
      q_b   <= ~q_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  end

  // Filter: q follows s only after s has disagreed with q for STABLE_CYCLES samples.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    q_n     = q;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s != q) begin
          if (STABLE_CYCLES > 1) begin
            state_n = ST_PEND;
            cnt_n   = CNT_W'(1);
          end else begin
            q_n    = s;
            rise_n = s;
            fall_n = ~s;
          end
        end
      end
      ST_PEND: begin
        if (s == q) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          q_n     = s;
          rise_n  = s;
          fall_n  = ~s;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: vector table, directed corner sequences, random vs model.
module tb_debounce_sync;

  localparam int unsigned SYNC_STAGES   = 2;
  localparam int unsigned STABLE_CYCLES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d   = 1'b0;
  logic q, q_b, rise, fall;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  debounce_sync #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES),
    .RESET_VAL     (1'b0)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .d    (d),
    .q    (q),
    .q_b  (q_b),
    .rise (rise),
    .fall (fall)
  );

  // Reference: delay line of samples plus a run length of samples disagreeing with q.
  logic [SYNC_STAGES-1:0] m_line = '0;
  logic m_q    = 1'b0;
  logic m_rise = 1'b0;
  logic m_fall = 1'b0;
  int   m_run  = 0;

  task automatic model_edge(input logic d_v, input logic rst_v);
    logic s_obs;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (rst_v) begin
      m_line = '0;
      m_q    = 1'b0;
      m_run  = 0;
    end else begin
      s_obs  = m_line[SYNC_STAGES-1];
      m_line = {m_line[SYNC_STAGES-2:0], d_v};
      if (s_obs != m_q) begin
        m_run = m_run + 1;
        if (m_run >= STABLE_CYCLES) begin
          m_rise = s_obs;
          m_fall = !s_obs;
          m_q    = s_obs;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive 2 ns after the previous edge, sample 1 ns after this edge.
  task automatic tick(input logic d_v, input logic rst_v);
    d   = d_v;
    rst = rst_v;
    @(posedge clk);
    model_edge(d_v, rst_v);
    #1;
    check("model", {28'd0, q, q_b, rise, fall}, {28'd0, m_q, ~m_q, m_rise, m_fall});
    #1;
  endtask

  typedef struct {
    logic rst;
    logic d;
    logic q;
    logic rise;
    logic fall;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int rise_at;
    int nrise;
    int npulse;
    int qhigh;
    logic val;
    logic [2:0] phases;

    // Reset held with d=1: outputs pinned at reset values.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      check("rst_q", {31'd0, q}, 32'd0);
      check("rst_qb", {31'd0, q_b}, 32'd1);
      check("rst_pulse", {30'd0, rise, fall}, 32'd0);
    end
    rise_at = -1;
    nrise   = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0);
      if (rise) begin
        nrise = nrise + 1;
        if (rise_at < 0) rise_at = i;
      end
    end
    check("rst_release_latency", rise_at, 32'd5);
    check("rst_release_nrise", nrise, 32'd1);
    check("rst_release_q", {31'd0, q}, 32'd1);

    // Table: release, press, release; 7 cycles each, output flips at t0+5.
    phases = 3'b010;
    for (int p = 0; p < 3; p++) begin
      val = phases[p];
      for (int k = 0; k < 7; k++) begin
        vecs.push_back('{rst: 1'b0, d: val,
                         q: (k >= 5) ? val : ~val,
                         rise: (k == 5) && val,
                         fall: (k == 5) && !val});
      end
    end
    foreach (vecs[i]) begin
      tick(vecs[i].d, vecs[i].rst);
      check("vec_q", {31'd0, q}, {31'd0, vecs[i].q});
      check("vec_qb", {31'd0, q_b}, {31'd0, ~vecs[i].q});
      check("vec_pulse", {30'd0, rise, fall}, {30'd0, vecs[i].rise, vecs[i].fall});
    end

    // Bounce: 1,1,0,1,1,1,0 then 1 held; only the held run may flip q.
    begin
      logic [6:0] bounce;
      bounce  = 7'b0111011;
      rise_at = -1;
      nrise   = 0;
      for (int i = 0; i < 19; i++) begin
        tick((i < 7) ? bounce[i] : 1'b1, 1'b0);
        if (i < 12) check("bounce_q_low", {31'd0, q}, 32'd0);
        if (rise) begin
          nrise = nrise + 1;
          if (rise_at < 0) rise_at = i;
        end
      end
      check("bounce_latency", rise_at, 32'd12);
      check("bounce_nrise", nrise, 32'd1);
    end
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b0);
    check("bounce_release_q", {31'd0, q}, 32'd0);

    // Reset at t0+3 discards the partial count.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    check("midrst_q", {31'd0, q}, 32'd0);
    check("midrst_pulse", {30'd0, rise, fall}, 32'd0);
    rise_at = -1;
    nrise   = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0);
      if (rise) begin
        nrise = nrise + 1;
        if (rise_at < 0) rise_at = i;
      end
    end
    check("midrst_latency", rise_at, 32'd5);
    check("midrst_nrise", nrise, 32'd1);
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b0);

    // One-cycle glitch every 3 cycles never reaches q.
    npulse = 0;
    qhigh  = 0;
    for (int i = 0; i < 30; i++) begin
      tick((i % 3) == 0, 1'b0);
      if (q) qhigh = qhigh + 1;
      if (rise || fall) npulse = npulse + 1;
    end
    check("glitch_qhigh", qhigh, 32'd0);
    check("glitch_pulses", npulse, 32'd0);

    // Random segments of varying length, occasional reset.
    for (int seg = 0; seg < 400; seg++) begin
      int unsigned len;
      logic dv, rv;
      len = $urandom_range(1, 8);
      dv  = 1'($urandom_range(0, 1));
      rv  = ($urandom_range(0, 63) == 0);
      for (int unsigned j = 0; j < len; j++) begin
        tick(dv, rv && (j == 0));
        check("rand_exclusive", {31'd0, rise & fall}, 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
